// File: rtl/gpu_sched_pkg.sv
// gpu_sched_pkg: shared header field positions, receive FSM states
// and width helpers for the per-core frame receiver.
package gpu_sched_pkg;

  localparam int HDR_CNT_LSB  = 0;
  localparam int HDR_CNT_MSB  = 5;
  localparam int HDR_FLAG_LSB = 6;
  localparam int HDR_FLAG_MSB = 7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    START,
    RUN
  } rx_state_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int len_w(input int depth);
    return addr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/core_frame_receiver_if.sv
// core_frame_receiver_if: shared 16-bit scheduler bus as seen by
// one core lane (scheduler is master, receiver is slave).
interface core_frame_receiver_if #(
  parameter int BUS_TO_CORE = 16
);
  logic                   frame_being_sent;
  logic                   bus_sof;
  logic [BUS_TO_CORE-1:0] bus_data;
  logic                   core_reading;

  modport master (
    output frame_being_sent,
    output bus_sof,
    output bus_data,
    input  core_reading
  );

  modport slave (
    input  frame_being_sent,
    input  bus_sof,
    input  bus_data,
    output core_reading
  );
endinterface

// File: rtl/core_imem.sv
// core_imem: simple dual-port RAM, one write port and one registered
// read port; a same-address read/write returns the old word.
module core_imem
  import gpu_sched_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [addr_w(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [addr_w(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write port and registered read port share one clocked process
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/core_frame_receiver.sv
// core_frame_receiver: loads a task from the scheduler bus into imem
// and pulses core_start. Optional RX_CHECKSUM_EN adds an XOR check word.
module core_frame_receiver
  import gpu_sched_pkg::*;
#(
  parameter int BUS_TO_CORE = 16,
  parameter int FRAME_SIZE  = 16,
  parameter int FRAME_NUM   = 64,
  parameter int IMEM_DEPTH  = 256
) (
  input  logic                            clk,
  input  logic                            reset,
  core_frame_receiver_if.slave            bus,
  input  logic                            core_sel,
  output logic                            core_ready,
  output logic                            core_start,
  output logic [1:0]                      task_flags,
  output logic [len_w(IMEM_DEPTH)-1:0]    load_len,
  output logic                            rx_err,
  input  logic                            core_done,
  input  logic [addr_w(IMEM_DEPTH)-1:0]   imem_rd_addr,
  output logic [BUS_TO_CORE-1:0]          imem_rd_data
);

  localparam int AW = addr_w(IMEM_DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = addr_w(FRAME_NUM);
  localparam int WW = addr_w(FRAME_SIZE);
  localparam int CW = HDR_CNT_MSB - HDR_CNT_LSB + 1;
  localparam logic [LW-1:0] DEPTH = LW'(IMEM_DEPTH);
  localparam logic [WW-1:0] WLAST = WW'(FRAME_SIZE - 1);

  rx_state_t state, state_nx, hdr_next, done_next;

  logic [BUS_TO_CORE-1:0] data;
  logic [CW-1:0]          hdr_cnt;
  logic [FW-1:0]          n_frames;
  logic [FW-1:0]          frame_cnt;
  logic [WW-1:0]          word_cnt;
  logic                   ovf;
  logic                   reading;
  logic                   acc;
  logic                   sof;
  logic                   word;
  logic                   take_hdr;
  logic                   ld_word;
  logic                   room;
  logic                   last;
  logic                   ovf_end;
  logic                   csum_ok;

  assign data     = bus.bus_data;
  assign hdr_cnt  = data[HDR_CNT_MSB:HDR_CNT_LSB];
  assign reading  = ~((state == RUN) & core_sel);
  assign bus.core_reading = reading;

  assign acc      = bus.frame_being_sent & core_sel & reading;
  assign sof      = acc & bus.bus_sof;
  assign word     = acc & ~bus.bus_sof;
  assign take_hdr = sof & ((state == IDLE) |
                           (state == LOAD) |
                           (state == CHECK));
  assign ld_word  = word & (state == LOAD);
  assign room     = load_len < DEPTH;
  assign ovf_end  = ovf | ~room;
  assign last     = (word_cnt == WLAST) &
                    (frame_cnt == n_frames - 1'b1);
  assign hdr_next = (hdr_cnt == '0) ? START : LOAD;

`ifdef RX_CHECKSUM_EN
  logic [BUS_TO_CORE-1:0] csum;

  assign done_next = CHECK;
  assign csum_ok   = (data == csum);

  // running XOR of every instruction word of the current task
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum <= '0;
    end else if (take_hdr) begin
      csum <= '0;
    end else if (ld_word) begin
      csum <= csum ^ data;
    end
  end
`else
  assign done_next = START;
  assign csum_ok   = 1'b1;
`endif

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state: headers restart in any receive state, end of task
  // branches on overflow
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (sof) state_nx = hdr_next;
      end
      LOAD: begin
        if (sof)
          state_nx = hdr_next;
        else if (word & last)
          state_nx = ovf_end ? IDLE : done_next;
      end
      CHECK: begin
        if (sof)
          state_nx = hdr_next;
        else if (word)
          state_nx = csum_ok ? START : IDLE;
      end
      START: state_nx = RUN;
      RUN: begin
        if (core_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // outputs decoded from state; rx_err flags the offending word's cycle
  always_comb begin
    core_ready = 1'b0;
    core_start = 1'b0;
    rx_err     = 1'b0;
    unique case (state)
      IDLE:  core_ready = 1'b1;
      LOAD:  rx_err = sof | (word & last & ovf_end);
      CHECK: rx_err = sof | (word & ~csum_ok);
      START: core_start = 1'b1;
      default: ;
    endcase
  end

  // header latch and frame/word/length counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_frames   <= '0;
      frame_cnt  <= '0;
      word_cnt   <= '0;
      load_len   <= '0;
      task_flags <= '0;
      ovf        <= 1'b0;
    end else if (take_hdr) begin
      n_frames   <= FW'(hdr_cnt);
      frame_cnt  <= '0;
      word_cnt   <= '0;
      load_len   <= '0;
      task_flags <= data[HDR_FLAG_MSB:HDR_FLAG_LSB];
      ovf        <= 1'b0;
    end else if (ld_word) begin
      if (word_cnt == WLAST) begin
        word_cnt  <= '0;
        frame_cnt <= frame_cnt + 1'b1;
      end else begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (room) load_len <= load_len + 1'b1;
      else      ovf      <= 1'b1;
    end
  end

  core_imem #(
    .DEPTH (IMEM_DEPTH),
    .WIDTH (BUS_TO_CORE)
  ) u_imem (
    .clk     (clk),
    .we      (ld_word & room),
    .wr_addr (load_len[AW-1:0]),
    .wr_data (data),
    .rd_addr (imem_rd_addr),
    .rd_data (imem_rd_data)
  );

endmodule
